memory_access_stage: RTL and testbench
======================================

# memory_access_stage

MEM stage of the pipeline, between the EX/MEM and MEM/WB pipeline registers. It issues loads, stores and RV32A atomics to the data memory port, handling byte/half/word alignment, sign extension and AMO read-modify-write sequencing. It also holds the LR/SC reservation. It stalls the upstream pipeline while a memory access is outstanding, and presents write-back data for the MEM/WB register.

## Interface
- No parameters.
- clock  input  1  stage clock
- reset  input  1  synchronous, active-high
- mem_result  input  32  ALU result; the address for memory ops, the write-back data otherwise
- mem_rs2_data_forwarded  input  32  store data / AMO operand
- mem_rd  input  5  destination register
- mem_reg_write  input  1  instruction writes rd
- mem_mem_write  input  1  store (incl. SC/AMO)
- mem_mem_read  input  1  load (incl. LR/AMO)
- mem_mem_op_length  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_atomic_op  input  5  project `ATOMIC_*` code (NO_OP, LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU)
- dmem_req  output  1  one-cycle request pulse
- dmem_we  output  1  write request when 1
- dmem_addr  output  32  word address ({addr[31:2],2'b00})
- dmem_wdata  output  32  lane-shifted write data
- dmem_wstrb  output  4  byte enables
- dmem_ready  input  1  one-cycle completion pulse, earliest 1 cycle after dmem_req
- dmem_rdata  input  32  read word, valid with dmem_ready
- stall  output  1  freeze EX/MEM and earlier stages
- wb_data  output  32  write-back value
- wb_rd  output  5  equals mem_rd
- wb_reg_write  output  1  write-back enable, 0 while stall=1

## Operation
- FSM states: IDLE, READ_WAIT, WRITE_WAIT. The state register, amo_old[31:0], res_valid and res_addr[31:2] are the only stateful elements.
- Non-memory instruction (read=write=0): in IDLE, wb_data=mem_result, wb_reg_write=mem_reg_write, stall=0, no request.
- Load / LR / AMO: in IDLE, pulse dmem_req (we=0), stall=1, go to READ_WAIT.
- READ_WAIT without dmem_ready: stall=1.
- Load or LR completes on dmem_ready: stall=0, wb_data=extracted value, go to IDLE. LR also sets res_valid=1 and res_addr=addr[31:2].
- AMO on dmem_ready: latch amo_old=rdata, pulse a write of f(rdata, rs2), stall=1, go to WRITE_WAIT.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned; SWAP writes rs2.
- Store in IDLE: pulse a write, stall=1, go to WRITE_WAIT.
- SC in IDLE:
  - If res_valid and res_addr matches: pulse a write, go to WRITE_WAIT, result 0.
  - Otherwise: no request, complete the same cycle with wb_data=1, stall=0.
  - Either way, res_valid is cleared.
- WRITE_WAIT on dmem_ready: stall=0, go to IDLE. wb_data is amo_old (AMO), 0 (SC), or don't-care for a plain store (reg_write=0).
- Lane handling (low address bits are ignored beyond the natural alignment):
  - B: strobe 1<<addr[1:0], wdata = rs2[7:0] replicated on all four lanes.
  - H: strobe 0011 or 1100 by addr[1], wdata = rs2[15:0] replicated.
  - W: strobe 1111.
  - Load data is taken from the addressed lane and sign-extended for B/H, zero-extended for BU/HU.
- A dmem_ready pulse arriving in IDLE is ignored.

## Timing
- During and after reset: state=IDLE, res_valid=0, amo_old=0, dmem_req=0, dmem_we=0, stall=0, wb_reg_write=0.
- Non-memory instruction and failed SC: 0-cycle latency (combinational pass-through).
- Load/store: stall spans from the issue cycle through the cycle before dmem_ready; the result is valid in the dmem_ready cycle. Minimum total is 2 cycles.
- AMO: 2 memory round trips, minimum 3 cycles.
- Inputs are stable while stall=1, because the upstream is frozen. In the completion cycle stall=0, and the next instruction is present one edge later in IDLE, so no request is re-issued for the same instruction.
- Reset mid-access: return to IDLE at the next edge and drop the outstanding transaction. A late dmem_ready is ignored.
- dmem_addr, dmem_wdata and dmem_wstrb are valid only in cycles with dmem_req=1.

## Test plan
- ALU pass-through: result=0x1234, reg_write=1, rd=5 -> same cycle wb_data=0x1234, wb_reg_write=1, stall=0, dmem_req=0.
- LB at address 0x103, rdata=0x80FFFFFF, ready 2 cycles after req -> stall=1 for 2 cycles, wb_data=0xFFFFFF80; the same access as LBU gives 0x00000080.
- SH at 0x202 with rs2=0xABCD -> dmem_we=1, dmem_addr=0x200, wstrb=1100, wdata[31:16]=0xABCD.
- AMOADD.W at 0x40, memory word 5, rs2=3 -> read, then write of wdata=8 with wstrb=1111; wb_data=5; 2 req pulses total.
- LR.W at 0x80, then SC.W at 0x80 -> write issued, wb_data=0. A second SC at 0x80 -> no request, wb_data=1, stall=0.
- Reset asserted in READ_WAIT, dmem_ready pulse 1 cycle after reset deasserts -> state IDLE, stall=0, wb_reg_write=0, pulse ignored.

Source files
------------

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues loads, stores and RV32A atomics to the data port,
// handles lane alignment, sign extension, AMO read-modify-write and LR/SC.
module memory_access_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_rs2_data_forwarded,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic        mem_mem_read,
  input  logic [2:0]  mem_mem_op_length,
  input  logic [4:0]  mem_atomic_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write
);

  localparam logic [4:0] ATOMIC_NO_OP = 5'd0;
  localparam logic [4:0] ATOMIC_LR    = 5'd1;
  localparam logic [4:0] ATOMIC_SC    = 5'd2;
  localparam logic [4:0] ATOMIC_SWAP  = 5'd3;
  localparam logic [4:0] ATOMIC_ADD   = 5'd4;
  localparam logic [4:0] ATOMIC_XOR   = 5'd5;
  localparam logic [4:0] ATOMIC_AND   = 5'd6;
  localparam logic [4:0] ATOMIC_OR    = 5'd7;
  localparam logic [4:0] ATOMIC_MIN   = 5'd8;
  localparam logic [4:0] ATOMIC_MAX   = 5'd9;
  localparam logic [4:0] ATOMIC_MINU  = 5'd10;
  localparam logic [4:0] ATOMIC_MAXU  = 5'd11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] amo_old_reg, amo_old_next;
  logic        res_valid_reg, res_valid_next;
  logic [29:0] res_addr_reg, res_addr_next;

  logic is_lr, is_sc, is_amo;
  assign is_lr  = (mem_atomic_op == ATOMIC_LR);
  assign is_sc  = (mem_atomic_op == ATOMIC_SC);
  assign is_amo = (mem_atomic_op >= ATOMIC_SWAP) && (mem_atomic_op <= ATOMIC_MAXU);

  logic [1:0]  byte_sel;
  logic [31:0] rs2;
  assign byte_sel = mem_result[1:0];
  assign rs2      = mem_rs2_data_forwarded;

  // Store lanes: narrow data is replicated so the strobe alone selects the lane.
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = rs2;
    case (mem_mem_op_length[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << byte_sel;
        st_wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        st_strb  = mem_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rs2[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = rs2;
      end
    endcase
  end

  logic [7:0] rd_lane [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;
  assign ld_byte = rd_lane[byte_sel];
  assign ld_half = mem_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (mem_mem_op_length)
      3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_value = {24'd0, ld_byte};
      3'b101:  load_value = {16'd0, ld_half};
      default: load_value = dmem_rdata;
    endcase
  end

  // New memory value for the write half of an AMO, from the word just read.
  logic [31:0] amo_result;
  always_comb begin
    case (mem_atomic_op)
      ATOMIC_SWAP: amo_result = rs2;
      ATOMIC_ADD:  amo_result = dmem_rdata + rs2;
      ATOMIC_XOR:  amo_result = dmem_rdata ^ rs2;
      ATOMIC_AND:  amo_result = dmem_rdata & rs2;
      ATOMIC_OR:   amo_result = dmem_rdata | rs2;
      ATOMIC_MIN:  amo_result = ($signed(dmem_rdata) < $signed(rs2)) ? dmem_rdata : rs2;
      ATOMIC_MAX:  amo_result = ($signed(dmem_rdata) > $signed(rs2)) ? dmem_rdata : rs2;
      ATOMIC_MINU: amo_result = (dmem_rdata < rs2) ? dmem_rdata : rs2;
      ATOMIC_MAXU: amo_result = (dmem_rdata > rs2) ? dmem_rdata : rs2;
      default:     amo_result = rs2;
    endcase
  end

  logic req_raw, we_raw, stall_raw;

  always_comb begin
    state_next     = state_reg;
    amo_old_next   = amo_old_reg;
    res_valid_next = res_valid_reg;
    res_addr_next  = res_addr_reg;
    req_raw        = 1'b0;
    we_raw         = 1'b0;
    stall_raw      = 1'b0;
    dmem_addr      = {mem_result[31:2], 2'b00};
    dmem_wdata     = st_wdata;
    dmem_wstrb     = st_strb;
    wb_data        = mem_result;

    case (state_reg)
      IDLE: begin
        if (mem_mem_write && is_sc) begin
          res_valid_next = 1'b0;
          if (res_valid_reg && (res_addr_reg == mem_result[31:2])) begin
            req_raw    = 1'b1;
            we_raw     = 1'b1;
            stall_raw  = 1'b1;
            state_next = WRITE_WAIT;
          end else begin
            wb_data = 32'd1;
          end
        end else if (mem_mem_read) begin
          req_raw    = 1'b1;
          stall_raw  = 1'b1;
          state_next = READ_WAIT;
        end else if (mem_mem_write) begin
          req_raw    = 1'b1;
          we_raw     = 1'b1;
          stall_raw  = 1'b1;
          state_next = WRITE_WAIT;
        end
      end

      READ_WAIT: begin
        stall_raw = 1'b1;
        if (dmem_ready) begin
          if (is_amo) begin
            amo_old_next = dmem_rdata;
            req_raw      = 1'b1;
            we_raw       = 1'b1;
            dmem_wdata   = amo_result;
            dmem_wstrb   = 4'b1111;
            state_next   = WRITE_WAIT;
          end else begin
            stall_raw  = 1'b0;
            wb_data    = load_value;
            state_next = IDLE;
            if (is_lr) begin
              res_valid_next = 1'b1;
              res_addr_next  = mem_result[31:2];
            end
          end
        end
      end

      WRITE_WAIT: begin
        stall_raw = 1'b1;
        if (dmem_ready) begin
          stall_raw  = 1'b0;
          state_next = IDLE;
          if (is_amo)
            wb_data = amo_old_reg;
          else if (is_sc)
            wb_data = 32'd0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Reset silences the port and the pipeline controls in the same cycle.
  assign dmem_req     = req_raw & ~reset;
  assign dmem_we      = we_raw & ~reset;
  assign stall        = stall_raw & ~reset;
  assign wb_rd        = mem_rd;
  assign wb_reg_write = mem_reg_write & ~stall_raw & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      amo_old_reg   <= 32'd0;
      res_valid_reg <= 1'b0;
      res_addr_reg  <= 30'd0;
    end else begin
      state_reg     <= state_next;
      amo_old_reg   <= amo_old_next;
      res_valid_reg <= res_valid_next;
      res_addr_reg  <= res_addr_next;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: pass-through, loads, stores, AMOs, LR/SC, reset.
module tb_memory_access_stage;

  localparam logic [4:0] A_NO_OP = 5'd0;
  localparam logic [4:0] A_LR    = 5'd1;
  localparam logic [4:0] A_SC    = 5'd2;
  localparam logic [4:0] A_SWAP  = 5'd3;
  localparam logic [4:0] A_ADD   = 5'd4;
  localparam logic [4:0] A_XOR   = 5'd5;
  localparam logic [4:0] A_AND   = 5'd6;
  localparam logic [4:0] A_OR    = 5'd7;
  localparam logic [4:0] A_MIN   = 5'd8;
  localparam logic [4:0] A_MAX   = 5'd9;
  localparam logic [4:0] A_MINU  = 5'd10;
  localparam logic [4:0] A_MAXU  = 5'd11;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_result, mem_rs2_data_forwarded;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_write, mem_mem_read;
  logic [2:0]  mem_mem_op_length;
  logic [4:0]  mem_atomic_op;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;

  int checks   = 0;
  int failures = 0;

  memory_access_stage dut (
    .clock(clock), .reset(reset),
    .mem_result(mem_result), .mem_rs2_data_forwarded(mem_rs2_data_forwarded),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
    .mem_mem_op_length(mem_mem_op_length), .mem_atomic_op(mem_atomic_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic [31:0] r2, input logic [4:0] rd,
                       input logic rw, input logic wr, input logic rdd,
                       input logic [2:0] len, input logic [4:0] atom);
    mem_result             = res;
    mem_rs2_data_forwarded = r2;
    mem_rd                 = rd;
    mem_reg_write          = rw;
    mem_mem_write          = wr;
    mem_mem_read           = rdd;
    mem_mem_op_length      = len;
    mem_atomic_op          = atom;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    drive(32'h10, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b010, A_NO_OP);
    tick();
    tick();
    checks++;
    if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++;
    if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL reset_wbwe: got %b want 0", wb_reg_write); end
    drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b010, A_NO_OP);
    reset = 1'b0;
    tick();
    $display("reset: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_passthrough();
    drive(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010, A_NO_OP);
    #1;
    checks++;
    if (wb_data !== 32'h1234 || wb_reg_write !== 1'b1 || wb_rd !== 5'd5)
      begin failures++; $display("FAIL alu_wb: got data=%h we=%b rd=%0d want 1234/1/5", wb_data, wb_reg_write, wb_rd); end
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0)
      begin failures++; $display("FAIL alu_ctl: got stall=%b req=%b want 0/0", stall, dmem_req); end
    tick();
    $display("passthrough: wb_data=%h", wb_data);
  endtask

  task automatic test_loads();
    logic [31:0] addr_t [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101};
    logic [2:0]  len_t  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] rd_t   [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FF1234, 32'h80FF1234, 32'hDEADBEEF, 32'h00007F00};
    logic [31:0] exp_t  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'hDEADBEEF, 32'h0000007F};
    for (int i = 0; i < 6; i++) begin
      drive(addr_t[i], 32'd0, 5'd7, 1'b1, 1'b0, 1'b1, len_t[i], A_NO_OP);
      #1;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {addr_t[i][31:2], 2'b00} || stall !== 1'b1)
        begin failures++; $display("FAIL load_issue[%0d]: got req=%b we=%b addr=%h stall=%b", i, dmem_req, dmem_we, dmem_addr, stall); end
      tick();
      checks++;
      if (stall !== 1'b1 || dmem_req !== 1'b0 || wb_reg_write !== 1'b0)
        begin failures++; $display("FAIL load_wait[%0d]: got stall=%b req=%b wbwe=%b want 1/0/0", i, stall, dmem_req, wb_reg_write); end
      tick();
      dmem_ready = 1'b1;
      dmem_rdata = rd_t[i];
      #1;
      checks++;
      if (stall !== 1'b0 || wb_data !== exp_t[i] || wb_reg_write !== 1'b1)
        begin failures++; $display("FAIL load_data[%0d]: got stall=%b data=%h we=%b want 0/%h/1", i, stall, wb_data, wb_reg_write, exp_t[i]); end
      $display("load[%0d] addr=%h len=%b wb_data=%h", i, addr_t[i], len_t[i], wb_data);
      tick();
      dmem_ready = 1'b0;
    end
  endtask

  task automatic test_stores();
    logic [31:0] addr_t [3] = '{32'h202, 32'h301, 32'h400};
    logic [2:0]  len_t  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] rs2_t  [3] = '{32'h0000ABCD, 32'h0000005A, 32'h01234567};
    logic [3:0]  strb_t [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd_t   [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h01234567};
    for (int i = 0; i < 3; i++) begin
      drive(addr_t[i], rs2_t[i], 5'd0, 1'b0, 1'b1, 1'b0, len_t[i], A_NO_OP);
      #1;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== {addr_t[i][31:2], 2'b00} || stall !== 1'b1)
        begin failures++; $display("FAIL store_issue[%0d]: got req=%b we=%b addr=%h stall=%b", i, dmem_req, dmem_we, dmem_addr, stall); end
      checks++;
      if (dmem_wstrb !== strb_t[i] || dmem_wdata !== wd_t[i])
        begin failures++; $display("FAIL store_lane[%0d]: got strb=%b wdata=%h want %b/%h", i, dmem_wstrb, dmem_wdata, strb_t[i], wd_t[i]); end
      tick();
      dmem_ready = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0 || wb_reg_write !== 1'b0)
        begin failures++; $display("FAIL store_done[%0d]: got stall=%b req=%b wbwe=%b want 0/0/0", i, stall, dmem_req, wb_reg_write); end
      $display("store[%0d] addr=%h strb=%b", i, addr_t[i], strb_t[i]);
      tick();
      dmem_ready = 1'b0;
    end
  endtask

  task automatic test_amo();
    logic [4:0]  op_t  [9] = '{A_ADD, A_SWAP, A_XOR, A_AND, A_OR, A_MIN, A_MAX, A_MINU, A_MAXU};
    logic [31:0] old_t [9] = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] rs2_t [9] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
    logic [31:0] new_t [9] = '{32'd8, 32'd3, 32'd5, 32'd2, 32'd7, 32'hFFFFFFFE, 32'd3, 32'd3, 32'hFFFFFFFE};
    int reqs;
    for (int i = 0; i < 9; i++) begin
      reqs = 0;
      drive(32'h40, rs2_t[i], 5'd9, 1'b1, 1'b1, 1'b1, 3'b010, op_t[i]);
      #1;
      if (dmem_req === 1'b1) reqs++;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40 || stall !== 1'b1)
        begin failures++; $display("FAIL amo_read[%0d]: got req=%b we=%b addr=%h stall=%b", i, dmem_req, dmem_we, dmem_addr, stall); end
      tick();
      dmem_ready = 1'b1;
      dmem_rdata = old_t[i];
      #1;
      if (dmem_req === 1'b1) reqs++;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== new_t[i] || dmem_wstrb !== 4'b1111 || stall !== 1'b1 || dmem_addr !== 32'h40)
        begin failures++; $display("FAIL amo_write[%0d]: got req=%b we=%b wdata=%h strb=%b stall=%b want wdata=%h", i, dmem_req, dmem_we, dmem_wdata, dmem_wstrb, stall, new_t[i]); end
      tick();
      dmem_rdata = 32'h0BAD0BAD;
      #1;
      if (dmem_req === 1'b1) reqs++;
      checks++;
      if (stall !== 1'b0 || wb_data !== old_t[i] || wb_reg_write !== 1'b1)
        begin failures++; $display("FAIL amo_done[%0d]: got stall=%b data=%h we=%b want 0/%h/1", i, stall, wb_data, wb_reg_write, old_t[i]); end
      checks++;
      if (reqs != 2)
        begin failures++; $display("FAIL amo_reqs[%0d]: got %0d want 2", i, reqs); end
      $display("amo[%0d] op=%0d old=%h new=%h wb=%h", i, op_t[i], old_t[i], dmem_wdata, wb_data);
      tick();
      dmem_ready = 1'b0;
    end
  endtask

  task automatic test_lr_sc();
    drive(32'h80, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 3'b010, A_LR);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11;
    #1;
    checks++;
    if (wb_data !== 32'h11 || stall !== 1'b0)
      begin failures++; $display("FAIL lr_data: got %h stall=%b want 11/0", wb_data, stall); end
    tick();
    dmem_ready = 1'b0;
    drive(32'h80, 32'h77, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, A_SC);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h80 || dmem_wdata !== 32'h77 || stall !== 1'b1)
      begin failures++; $display("FAIL sc_issue: got req=%b we=%b addr=%h wdata=%h stall=%b", dmem_req, dmem_we, dmem_addr, dmem_wdata, stall); end
    tick();
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (wb_data !== 32'd0 || stall !== 1'b0 || wb_reg_write !== 1'b1)
      begin failures++; $display("FAIL sc_ok: got data=%h stall=%b we=%b want 0/0/1", wb_data, stall, wb_reg_write); end
    $display("sc first wb_data=%h", wb_data);
    tick();
    dmem_ready = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || wb_data !== 32'd1 || stall !== 1'b0 || wb_reg_write !== 1'b1)
      begin failures++; $display("FAIL sc_fail: got req=%b data=%h stall=%b we=%b want 0/1/0/1", dmem_req, wb_data, stall, wb_reg_write); end
    $display("sc second wb_data=%h", wb_data);
    // Reservation on another word, mismatched SC fails, then the matching one too.
    tick();
    drive(32'h84, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 3'b010, A_LR);
    tick();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    drive(32'h80, 32'h55, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, A_SC);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || wb_data !== 32'd1)
      begin failures++; $display("FAIL sc_addr: got req=%b data=%h want 0/1", dmem_req, wb_data); end
    tick();
    drive(32'h84, 32'h55, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, A_SC);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || wb_data !== 32'd1)
      begin failures++; $display("FAIL sc_cleared: got req=%b data=%h want 0/1", dmem_req, wb_data); end
    $display("sc after clear wb_data=%h", wb_data);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(32'h10, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b010, A_NO_OP);
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || wb_reg_write !== 1'b0)
      begin failures++; $display("FAIL rst_mid: got stall=%b req=%b we=%b want 0/0/0", stall, dmem_req, wb_reg_write); end
    tick();
    reset = 1'b0;
    drive(32'hCAFE, 32'd0, 5'd6, 1'b0, 1'b0, 1'b0, 3'b010, A_NO_OP);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h12345678;
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || wb_reg_write !== 1'b0 || wb_data !== 32'hCAFE)
      begin failures++; $display("FAIL late_ready: got stall=%b req=%b we=%b data=%h want 0/0/0/cafe", stall, dmem_req, wb_reg_write, wb_data); end
    tick();
    dmem_ready = 1'b0;
    drive(32'h20, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b010, A_NO_OP);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall !== 1'b1)
      begin failures++; $display("FAIL post_rst_issue: got req=%b stall=%b want 1/1", dmem_req, stall); end
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h00000042;
    #1;
    checks++;
    if (wb_data !== 32'h42 || stall !== 1'b0)
      begin failures++; $display("FAIL post_rst_load: got %h stall=%b want 42/0", wb_data, stall); end
    $display("reset mid-access recovered wb_data=%h", wb_data);
    tick();
    dmem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_amo();
    test_lr_sc();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
